// File: rtl/node_port_ctrl.sv
// Port controller for a grid node: moves one byte per request between the
// execute stage and the four neighbour links, with round-robin arbitration for ANY.
module node_port_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_dir,
    input  logic [7:0]  wr_data,
    output logic [7:0]  rd_data,
    output logic        req_done,
    output logic        stall,
    input  logic [3:0]  in_valid,
    input  logic [31:0] in_data,
    output logic [3:0]  in_ack,
    output logic [3:0]  out_valid,
    output logic [7:0]  out_data,
    input  logic [3:0]  out_ack,
    output logic [1:0]  last_dir,
    output logic        last_valid
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

    localparam logic [2:0] DIR_ANY  = 3'd4;
    localparam logic [2:0] DIR_LAST = 3'd5;
    localparam logic [2:0] DIR_NIL  = 3'd6;

    state_t     state;
    logic [2:0] dir_q;
    logic [1:0] rr_ptr;
    logic [2:0] req_dir_res;
    logic [3:0] hit;
    logic [1:0] win;
    logic [3:0] sel_mask;

    // First set bit of hit at or above ptr, wrapping 3 -> 0.
    function automatic logic [1:0] rr_pick(input logic [3:0] h, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] w;
        w = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (h[idx]) w = idx;
        end
        return w;
    endfunction

    function automatic logic [2:0] resolve_dir(input logic [2:0] d, input logic lv,
                                               input logic [1:0] ld);
        logic [2:0] r;
        if (d <= DIR_ANY)       r = d;
        else if (d == DIR_LAST) r = lv ? {1'b0, ld} : DIR_NIL;
        else                    r = DIR_NIL;
        return r;
    endfunction

    assign req_dir_res = resolve_dir(req_dir, last_valid, last_dir);
    assign sel_mask    = (req_dir_res == DIR_ANY) ? 4'b1111 : (4'b0001 << req_dir_res[1:0]);
    // Only the registered offer/accept masks qualify a transfer, so unselected lanes never win.
    assign hit         = (state == RD_WAIT) ? (in_valid & in_ack) : (out_valid & out_ack);
    assign win         = rr_pick(hit, rr_ptr);
    assign stall       = !rst && (((state == IDLE) && req_valid) ||
                                  (state == RD_WAIT) || (state == WR_WAIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dir_q      <= 3'd0;
            rd_data    <= 8'd0;
            req_done   <= 1'b0;
            in_ack     <= 4'd0;
            out_valid  <= 4'd0;
            out_data   <= 8'd0;
            last_dir   <= 2'd0;
            last_valid <= 1'b0;
            rr_ptr     <= 2'd0;
        end else begin
            req_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        dir_q <= req_dir_res;
                        if (req_dir_res == DIR_NIL) begin
                            state    <= DONE;
                            req_done <= 1'b1;
                            if (!req_write) rd_data <= 8'd0;
                        end else if (req_write) begin
                            state     <= WR_WAIT;
                            out_data  <= wr_data;
                            out_valid <= sel_mask;
                        end else begin
                            state  <= RD_WAIT;
                            in_ack <= sel_mask;
                        end
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    if (|hit) begin
                        if (state == RD_WAIT) rd_data <= in_data[{win, 3'b000} +: 8];
                        in_ack    <= 4'd0;
                        out_valid <= 4'd0;
                        state     <= DONE;
                        req_done  <= 1'b1;
                        if (dir_q == DIR_ANY) begin
                            last_dir   <= win;
                            last_valid <= 1'b1;
                            rr_ptr     <= win + 2'd1;
                        end
                    end
                end
                DONE: state <= IDLE;
            endcase
        end
    end

endmodule
